// File: rtl/cnt_sched_pkg.sv
// Shared types and default sizing for the count scheduler.
package cnt_sched_pkg;

  localparam int unsigned NREQ_DEF  = 4;
  localparam int unsigned WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/tick_counter.sv
// Shared run-length counter: synchronous clear, enable-gated increment.
module tick_counter
  import cnt_sched_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  // Clear wins over increment; the owner guarantees en never asks for a wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/count_scheduler.sv
// Round-robin arbiter that lends one shared counter to a requester for a
// latched number of cycles, then pulses done (qualified by aborted).
module count_scheduler
  import cnt_sched_pkg::*;
#(
  parameter int unsigned NREQ  = NREQ_DEF,
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] len,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic [NREQ-1:0]       done,
  output logic                  aborted,
  output logic [WIDTH-1:0]      count
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t           state, state_next;
  logic [NREQ-1:0]  gnt_next, done_next;
  logic             busy_next, aborted_next;
  logic [WIDTH-1:0] limit, limit_next;
  logic [IDX_W-1:0] winner, winner_next;
  logic [IDX_W-1:0] ptr, ptr_next;
  logic [IDX_W-1:0] pick;
  logic             clr, en;

  // First asserted request after the last winner, wrapping at NREQ.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ-1:0] r,
                                               input logic [IDX_W-1:0] p);
    logic [IDX_W-1:0] sel;
    logic             found;
    int unsigned      j;
    sel   = p;
    found = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      j = (32'(p) + k) % NREQ;
      if (!found && r[j]) begin
        sel   = IDX_W'(j);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] i);
    return NREQ'(1) << i;
  endfunction

  tick_counter #(.WIDTH(WIDTH)) u_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .en    (en),
    .count (count)
  );

  // State and all registered outputs; reset leaves ptr so requester 0 wins first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      gnt     <= '0;
      done    <= '0;
      aborted <= 1'b0;
      busy    <= 1'b0;
      limit   <= '0;
      winner  <= '0;
      ptr     <= IDX_W'(NREQ - 1);
    end else begin
      state   <= state_next;
      gnt     <= gnt_next;
      done    <= done_next;
      aborted <= aborted_next;
      busy    <= busy_next;
      limit   <= limit_next;
      winner  <= winner_next;
      ptr     <= ptr_next;
    end
  end

  // Next state, next registered outputs and counter controls.
  always_comb begin
    state_next   = state;
    gnt_next     = gnt;
    done_next    = '0;
    aborted_next = 1'b0;
    limit_next   = limit;
    winner_next  = winner;
    ptr_next     = ptr;
    clr          = 1'b0;
    en           = 1'b0;
    pick         = rr_pick(req, ptr);

    case (state)
      IDLE: begin
        gnt_next = '0;
        if (|req) begin
          winner_next = pick;
          gnt_next    = onehot(pick);
          for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick == IDX_W'(i)) limit_next = len[i*WIDTH +: WIDTH];
          end
          state_next = LOAD;
        end
      end
      LOAD: begin
        clr = 1'b1;
        // A zero-length run is complete on arrival, so it is never an abort.
        if (limit == '0) begin
          state_next = DONE;
          done_next  = onehot(winner);
        end else if (!req[winner]) begin
          state_next   = DONE;
          done_next    = onehot(winner);
          aborted_next = 1'b1;
        end else begin
          state_next = RUN;
        end
      end
      RUN: begin
        // Reaching the last count takes priority over a simultaneous drop.
        if (count == limit - WIDTH'(1)) begin
          state_next = DONE;
          done_next  = onehot(winner);
        end else if (!req[winner]) begin
          state_next   = DONE;
          done_next    = onehot(winner);
          aborted_next = 1'b1;
        end else begin
          en = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
        gnt_next   = '0;
        ptr_next   = winner;
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

endmodule
